m_axi_cmd: RTL
==============

M_AXI_CMD -- requirements
Module: m_axi_cmd

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'h0: ID driven on awid_o/wid_o/arid_o and expected on bid_i/rid_i.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit, 8-bit, used only when M_AXI_CMD_TIMEOUT_EN is defined.
REQ-003 SHALL have ports: clk in 1 (single clock); areset in 1 (synchronous, active-high reset).
REQ-004 Command ports: cmd_valid_i in 1; cmd_ready_o out 1; cmd_write_i in 1 (1=write, 0=read); cmd_addr_i in 32; cmd_wdata_i in 32; cmd_wstrb_i in 4.
REQ-005 Response ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_write_o out 1; rsp_rdata_o out 32; rsp_err_o out 1; rsp_timeout_o out 1.
REQ-006 AXI write ports: awid_o out 4; awaddr_o out 32; awvalid_o out 1; awready_i in 1; wid_o out 4; wdata_o out 32; wstrb_o out 4; wlast_o out 1; wvalid_o out 1; wready_i in 1; bid_i in 4; bresp_i in 2; bvalid_i in 1; bready_o out 1.
REQ-007 AXI read ports: arid_o out 4; araddr_o out 32; arvalid_o out 1; arready_i in 1; rid_i in 4; rdata_i in 32; rstrb_i in 4 (ignored); rlast_i in 1; rvalid_i in 1; rready_o out 1.

Function
REQ-008 SHALL implement FSM states IDLE, WRITE, WRESP, RADDR, RDATA, RSP; one transaction outstanding; single-beat only.
REQ-009 cmd_ready_o SHALL be 1 only in IDLE; accept = cmd_valid_i && cmd_ready_o; command fields registered on accept.
REQ-010 On write accept, next cycle SHALL enter WRITE with awvalid_o=1 and wvalid_o=1 simultaneously; wlast_o=1 whenever wvalid_o=1.
REQ-011 awvalid_o SHALL drop the cycle after its handshake; wvalid_o likewise, independently; either order or same-cycle handshakes allowed.
REQ-012 awaddr_o/wdata_o/wstrb_o SHALL stay stable while corresponding valid is high; valids never drop without handshake (except reset/timeout).
REQ-013 When both AW and W done, SHALL enter WRESP with bready_o=1; on bvalid_i && bready_o capture response, enter RSP.
REQ-014 On read accept, SHALL enter RADDR with arvalid_o=1; on arready_i enter RDATA with arvalid_o=0, rready_o=1; on rvalid_i capture rdata_i, enter RSP.
REQ-015 Write rsp_err_o SHALL = (bresp_i != 2'b00) || (bid_i != AXI_ID); read rsp_err_o SHALL = (rid_i != AXI_ID) || !rlast_i.
REQ-016 In RSP, rsp_valid_o=1 with rsp_write_o, rsp_rdata_o (0 for writes), rsp_err_o held stable until rsp_ready_i; then IDLE next cycle.
REQ-017 Minimum latency with zero-wait slave: accept at edge N, rsp_valid_o high at edge N+3; cmd_ready_o high again the cycle after rsp handshake.
REQ-018 bvalid_i/rvalid_i outside WRESP/RDATA SHALL be ignored (ready low).

Reset
REQ-019 areset sampled at posedge clk SHALL force IDLE next edge, including mid-transaction.
REQ-020 Reset values: cmd_ready_o=1 (after reset release edge), all AXI valid/ready outputs 0, rsp_valid_o=0, rsp_err_o=0, rsp_timeout_o=0, rsp_rdata_o=0, awaddr_o/araddr_o/wdata_o=0, wstrb_o=0, wlast_o=0, IDs=AXI_ID.

Configuration
REQ-021 Macro M_AXI_CMD_TIMEOUT_EN defined: 8-bit counter cleared on each state entry, increments in WRITE/WRESP/RADDR/RDATA; on reaching TIMEOUT_CYCLES SHALL drop all AXI valid/ready, enter RSP with rsp_err_o=1, rsp_timeout_o=1.
REQ-022 Macro undefined: no counter; rsp_timeout_o tied 0; waits indefinitely.

Verification
REQ-023 Write addr 0x4, data 0xDEADBEEF, strb 0xF, slave ready immediately, bresp=0 -> AW/W one cycle each, rsp_valid at N+3, rsp_err=0.
REQ-024 Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable awaddr, bready only after both.
REQ-025 Read addr 0x8, slave returns rdata 0x12345678, rid=AXI_ID, rlast=1 -> rsp_rdata=0x12345678, rsp_write=0, rsp_err=0.
REQ-026 Write with bresp=2'b10, and read with rid=4'h3 (AXI_ID=0) -> rsp_err=1 both.
REQ-027 areset asserted during WRESP -> next edge all valids/readies 0, state IDLE, cmd_ready_o=1 after release.
REQ-028 With M_AXI_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=8, arready held 0 -> arvalid drops after 8 cycles, rsp_err=1, rsp_timeout=1.

Source files
------------

// File: rtl/m_axi_cmd.sv
// Single-outstanding, single-beat AXI master that turns a simple command/response pair into AW/W/B or AR/R traffic.
// Optional watchdog enabled by defining M_AXI_CMD_TIMEOUT_EN.
module m_axi_cmd #(
    parameter logic [3:0] AXI_ID         = 4'h0,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_write_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [3:0]  bid_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o,
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic [3:0]  rstrb_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o
);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RSP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  strb_q;
    logic        write_q, aw_done_q, w_done_q, err_q;
    logic        accept, aw_hs, w_hs, b_hs, r_hs, tmo;

    assign accept = cmd_valid_i && cmd_ready_o;
    assign aw_hs  = awvalid_o && awready_i;
    assign w_hs   = wvalid_o && wready_i;
    assign b_hs   = bvalid_i && bready_o;
    assign r_hs   = rvalid_i && rready_o;

    // Payload outputs come straight from the command registers, so they are
    // stable for the whole time the matching valid is up.
    assign awid_o      = AXI_ID;
    assign wid_o       = AXI_ID;
    assign arid_o      = AXI_ID;
    assign awaddr_o    = addr_q;
    assign araddr_o    = addr_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = strb_q;
    assign rsp_write_o = write_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

`ifdef M_AXI_CMD_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       tmo_q, waiting;

    assign waiting       = (state_q == WRITE) || (state_q == WRESP) ||
                           (state_q == RADDR) || (state_q == RDATA);
    // Fires on the last allowed wait cycle so valids are up exactly TIMEOUT_CYCLES cycles.
    assign tmo           = waiting && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign rsp_timeout_o = tmo_q;

    always_ff @(posedge clk) begin
        if (areset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (state_d != state_q) cnt_q <= '0;
            else if (waiting)       cnt_q <= cnt_q + 8'd1;
            if (accept)   tmo_q <= 1'b0;
            else if (tmo) tmo_q <= 1'b1;
        end
    end
`else
    assign tmo           = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        awvalid_o   = 1'b0;
        wvalid_o    = 1'b0;
        bready_o    = 1'b0;
        arvalid_o   = 1'b0;
        rready_o    = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_d = cmd_write_i ? WRITE : RADDR;
            end
            WRITE: begin
                awvalid_o = !aw_done_q;
                wvalid_o  = !w_done_q;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WRESP;
            end
            WRESP: begin
                bready_o = 1'b1;
                if (bvalid_i) state_d = RSP;
            end
            RADDR: begin
                arvalid_o = 1'b1;
                if (arready_i) state_d = RDATA;
            end
            RDATA: begin
                rready_o = 1'b1;
                if (rvalid_i) state_d = RSP;
            end
            RSP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (tmo) state_d = RSP;
    end

    assign wlast_o = wvalid_o;

    always_ff @(posedge clk) begin
        if (areset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            write_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= cmd_addr_i;
                wdata_q   <= cmd_wdata_i;
                strb_q    <= cmd_wstrb_i;
                write_q   <= cmd_write_i;
                rdata_q   <= '0;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                err_q     <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (b_hs)  err_q     <= (bresp_i != 2'b00) || (bid_i != AXI_ID);
            if (r_hs) begin
                rdata_q <= rdata_i;
                err_q   <= (rid_i != AXI_ID) || !rlast_i;
            end
            if (tmo) err_q <= 1'b1;
        end
    end

endmodule
